titan_alu_decode: RTL and testbench
===================================

// Module: titan_alu_decode
// PURPOSE
//  Decode stage feeding titan_exu. It accepts one RV32I integer instruction per handshake and
//  decodes OP, OP-IMM, LUI and AUIPC. It resolves operands from register-file read data, with
//  optional writeback forwarding, and registers port_a, port_b and alu_op for the execute stage.
//  It is a single-entry pipeline register with valid/ready on both sides and a flush input.
// PARAMETERS
//  FWD_EN      1      1: bypass wb_data onto matching rs1/rs2; 0: regfile data only
//  ILLEGAL_OP  4'hF   alu_op emitted for an illegal instruction (the EXU returns 0 for it)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   reset, asynchronous assert, active-low
//  in_valid     in   1   upstream instruction valid
//  in_ready     out  1   stage can accept; = !out_valid | out_ready (combinational)
//  in_instr     in   32  instruction word
//  in_pc        in   32  instruction PC
//  rs1_addr     out  5   = in_instr[19:15], combinational, to regfile
//  rs2_addr     out  5   = in_instr[24:20], combinational, to regfile
//  rs1_data     in   32  regfile read data for rs1_addr, same cycle
//  rs2_data     in   32  regfile read data for rs2_addr, same cycle
//  wb_en        in   1   writeback this cycle
//  wb_rd        in   5   writeback destination
//  wb_data      in   32  writeback value
//  flush        in   1   kill held and incoming instruction
//  out_valid    out  1   decoded op valid toward EXU
//  out_ready    in   1   EXU/next stage accepts
//  out_port_a   out  32  EXU port_a
//  out_port_b   out  32  EXU port_b
//  out_alu_op   out  4   0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRA,7 SRL,8 SLT,9 SLTU
//  out_rd       out  5   destination register
//  out_wb_en    out  1   1 if legal and rd != 0
//  out_illegal  out  1   unsupported opcode/funct encoding
// BEHAVIOUR
//  - Reset: out_valid=0, all other registered outputs 0. in_ready=1 while reset is active.
//  - Accept when in_valid & in_ready. Outputs update on the next edge; latency is 1 cycle.
//  - Hold: while out_valid & !out_ready, all out_* are stable and in_ready=0.
//  - Accept + drain in the same cycle is allowed (out_ready=1): full throughput, 1 op/cycle.
//  - Edge with nothing accepted and out_ready=1: out_valid<=0.
//  - flush=1: out_valid<=0 on the next edge and nothing is captured, even if in_valid & in_ready.
//    flush has priority over accept.
//  - Operand value: x0 reads 0. If FWD_EN & wb_en & wb_rd==rsN & rsN!=0, use wb_data,
//    else rsN_data.
//  - OP (0110011): a=rs1, b=rs2.
//    - funct7=0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
//    - funct7=0100000: f3 000 SUB, 101 SRA.
//    - Any other funct7/f3 pair (including M-extension) is illegal.
//  - OP-IMM (0010011): a=rs1, b=sign-extended imm[31:20]. Same f3 map as OP, with no SUB.
//    - f3=001 needs imm[31:25]=0000000.
//    - f3=101 needs imm[31:25]=0000000 (SRL) or 0100000 (SRA). Otherwise illegal.
//  - Shifts (OP and OP-IMM): b is masked to {27'b0, b[4:0]} because the EXU shifts by the full b.
//  - LUI (0110111): a=0, b={instr[31:12],12'b0}, ADD.
//  - AUIPC (0010111): a=in_pc, b={instr[31:12],12'b0}, ADD.
//  - Illegal: out_valid=1, out_illegal=1, out_alu_op=ILLEGAL_OP, out_port_a=out_port_b=0,
//    out_wb_en=0.
//  - out_rd=instr[11:7] for every instruction. rd=0 gives out_wb_en=0.
//  - rst_n low mid-transfer: outputs clear immediately. The held instruction is lost, no replay.
// TESTING
//  - ADDI x5,x1,-1 (0xFFF08293), rs1_data=10 -> next cycle: a=10, b=0xFFFFFFFF, op=0,
//    rd=5, wb_en=1.
//  - SRAI x3,x2,4 (0x40415193) -> b=4, op=6. SRA x3,x2,x4 with rs2_data=0x24 -> b=4, op=6.
//  - SLLI with imm[31:25]=0000001 and MUL (funct7=0000001) -> illegal=1, op=4'hF, wb_en=0.
//  - Stream 3 ops with out_ready=0 for 2 cycles: out_* stay frozen, in_ready=0. Then 1 op/cycle,
//    no drop or duplicate.
//  - FWD_EN=1, wb_en=1, wb_rd=1, wb_data=0x55, rs1_data=0x11, rs1=x1 -> a=0x55.
//    rs1=x0 with wb_rd=0 -> a=0.
//  - AUIPC x1,0x12345 at pc=0x100 -> a=0x100, b=0x12345000. flush the same cycle ->
//    out_valid=0 next cycle. rst_n pulse while holding -> out_valid=0 at once.

Source files
------------

// File: rtl/titan_alu_decode.sv
// RV32I decode stage for titan_exu: decodes OP, OP-IMM, LUI and AUIPC into EXU operands
// and an ALU opcode, held in a single-entry valid/ready pipeline register with flush.
module titan_alu_decode #(
  parameter bit         FWD_EN     = 1'b1,
  parameter logic [3:0] ILLEGAL_OP = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_port_a,
  output logic [31:0] out_port_b,
  output logic [3:0]  out_alu_op,
  output logic [4:0]  out_rd,
  output logic        out_wb_en,
  output logic        out_illegal
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRA  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  // funct3 -> ALU op for the base (funct7 = 0) encodings shared by OP and OP-IMM.
  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign imm_i    = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u    = {in_instr[31:12], 12'b0};
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  always_comb begin
    rs1_val = rs1_data;
    rs2_val = rs2_data;
    if (FWD_EN && wb_en && (wb_rd == rs1_addr)) rs1_val = wb_data;
    if (FWD_EN && wb_en && (wb_rd == rs2_addr)) rs2_val = wb_data;
    if (rs1_addr == 5'd0) rs1_val = '0;
    if (rs2_addr == 5'd0) rs2_val = '0;
  end

  logic        valid_q;
  logic [31:0] port_a_q, port_a_d;
  logic [31:0] port_b_q, port_b_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [4:0]  rd_q;
  logic        wb_en_q, wb_en_d;
  logic        illegal_q;
  logic        legal;
  logic        is_shift;
  logic        accept;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    legal    = 1'b0;
    is_shift = 1'b0;
    alu_op_d = ALU_ADD;
    port_a_d = '0;
    port_b_d = '0;
    case (opcode)
      OPC_OP: begin
        port_a_d = rs1_val;
        port_b_d = rs2_val;
        is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
        if (funct7 == F7_BASE) begin
          legal    = 1'b1;
          alu_op_d = base_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          legal    = 1'b1;
          alu_op_d = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          legal    = 1'b1;
          alu_op_d = ALU_SRA;
        end
      end
      OPC_IMM: begin
        port_a_d = rs1_val;
        port_b_d = imm_i;
        is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
        alu_op_d = base_op(funct3);
        case (funct3)
          3'b001: legal = (funct7 == F7_BASE);
          3'b101: begin
            legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            if (funct7 == F7_ALT) alu_op_d = ALU_SRA;
          end
          default: legal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        legal    = 1'b1;
        port_b_d = imm_u;
      end
      OPC_AUIPC: begin
        legal    = 1'b1;
        port_a_d = in_pc;
        port_b_d = imm_u;
      end
      default: ;
    endcase
    // The EXU shifts by the whole of port_b, so only the 5-bit shift amount may survive.
    if (is_shift) port_b_d = {27'b0, port_b_d[4:0]};
    if (!legal) begin
      port_a_d = '0;
      port_b_d = '0;
      alu_op_d = ILLEGAL_OP;
    end
    wb_en_d = legal && (in_instr[11:7] != 5'd0);
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      port_a_q  <= '0;
      port_b_q  <= '0;
      alu_op_q  <= '0;
      rd_q      <= '0;
      wb_en_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      port_a_q  <= port_a_d;
      port_b_q  <= port_b_d;
      alu_op_q  <= alu_op_d;
      rd_q      <= in_instr[11:7];
      wb_en_q   <= wb_en_d;
      illegal_q <= !legal;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_port_a  = port_a_q;
  assign out_port_b  = port_b_q;
  assign out_alu_op  = alu_op_q;
  assign out_rd      = rd_q;
  assign out_wb_en   = wb_en_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_titan_alu_decode.sv
// Bench for titan_alu_decode: directed cases plus randomized traffic, each cycle compared
// against a spec-level model of the decoded op and the one-entry handshake register.
module tb_titan_alu_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_port_a, out_port_b;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_wb_en, out_illegal;

  always #5 clk = ~clk;

  titan_alu_decode dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_port_a(out_port_a), .out_port_b(out_port_b), .out_alu_op(out_alu_op),
    .out_rd(out_rd), .out_wb_en(out_wb_en), .out_illegal(out_illegal)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } exp_t;

  // ALU code per funct3 for the base encodings, nibble f3 holds the code for that funct3.
  localparam logic [31:0] F3_TABLE = {4'd2, 4'd3, 4'd7, 4'd4, 4'd9, 4'd8, 4'd5, 4'd0};

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] regs [32];
  exp_t        m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] va, input logic [31:0] vb);
    exp_t        r;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ok;
    opc     = ins[6:0];
    f3      = ins[14:12];
    f7      = ins[31:25];
    ok      = 1'b0;
    r       = '0;
    r.valid = 1'b1;
    r.rd    = ins[11:7];
    if (opc == 7'h33) begin
      r.a  = va;
      r.b  = vb;
      r.op = F3_TABLE[{f3, 2'b00} +: 4];
      ok   = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      if (f7 == 7'h20) r.op = (f3 == 3'd0) ? 4'd1 : 4'd6;
    end else if (opc == 7'h13) begin
      r.a  = va;
      r.b  = {{20{ins[31]}}, ins[31:20]};
      r.op = F3_TABLE[{f3, 2'b00} +: 4];
      ok   = 1'b1;
      if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
      if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ok = 1'b0;
      if (f3 == 3'd5 && f7 == 7'h20) r.op = 4'd6;
    end else if (opc == 7'h37 || opc == 7'h17) begin
      ok   = 1'b1;
      r.a  = (opc == 7'h17) ? pc : 32'd0;
      r.b  = ins[31:12] * 32'd4096;
      r.op = 4'd0;
    end
    if ((opc == 7'h33 || opc == 7'h13) && (f3 == 3'd1 || f3 == 3'd5)) r.b = r.b % 32;
    if (!ok) begin
      r.a  = 0;
      r.b  = 0;
      r.op = 4'hF;
    end
    r.ill = !ok;
    r.wb  = ok && (r.rd != 0);
    return r;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic wbe,
                                          input logic [4:0] wbr, input logic [31:0] wbd);
    if (rs == 0) return 0;
    if (wbe && wbr == rs) return wbd;
    return regs[rs];
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, {31'b0, out_valid}, {31'b0, m.valid});
    if (m.valid) begin
      check({tag, ".a"}, out_port_a, m.a);
      check({tag, ".b"}, out_port_b, m.b);
      check({tag, ".op"}, {28'b0, out_alu_op}, {28'b0, m.op});
      check({tag, ".rd"}, {27'b0, out_rd}, {27'b0, m.rd});
      check({tag, ".wb_en"}, {31'b0, out_wb_en}, {31'b0, m.wb});
      check({tag, ".illegal"}, {31'b0, out_illegal}, {31'b0, m.ill});
    end
  endtask

  // Present one cycle of inputs (called just after a rising edge), then check the next state.
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic ordy, input logic fl,
                      input logic wbe, input logic [4:0] wbr, input logic [31:0] wbd);
    exp_t nx;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    wb_en     = wbe;
    wb_rd     = wbr;
    wb_data   = wbd;
    rs1_data  = regs[ins[19:15]];
    rs2_data  = regs[ins[24:20]];
    #1;
    check({tag, ".rs1_addr"}, {27'b0, rs1_addr}, {27'b0, ins[19:15]});
    check({tag, ".rs2_addr"}, {27'b0, rs2_addr}, {27'b0, ins[24:20]});
    check({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, (!m.valid || ordy)});
    nx = m;
    if (fl) nx.valid = 1'b0;
    else if (v && (!m.valid || ordy))
      nx = ref_decode(ins, pc, operand(ins[19:15], wbe, wbr, wbd),
                      operand(ins[24:20], wbe, wbr, wbd));
    else if (ordy) nx.valid = 1'b0;
    @(posedge clk);
    #1;
    m = nx;
    check_outputs(tag);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, ".a"}, out_port_a, 32'd0);
    check({tag, ".b"}, out_port_b, 32'd0);
    check({tag, ".op"}, {28'b0, out_alu_op}, 32'd0);
    check({tag, ".rd"}, {27'b0, out_rd}, 32'd0);
    check({tag, ".wb_en"}, {31'b0, out_wb_en}, 32'd0);
    check({tag, ".illegal"}, {31'b0, out_illegal}, 32'd0);
    check({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] sra_r, slli_bad, mul_i, add_fwd, add_x0, auipc_i, op1, op2, op3, ins;
    logic [6:0]  opc, f7;
    logic [4:0]  wbr;

    sra_r    = {7'b0100000, 5'd4, 5'd2, 3'b101, 5'd3, 7'b0110011};
    slli_bad = {7'b0000001, 5'd3, 5'd2, 3'b001, 5'd6, 7'b0010011};
    mul_i    = {7'b0000001, 5'd3, 5'd2, 3'b000, 5'd7, 7'b0110011};
    add_fwd  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd8, 7'b0110011};
    add_x0   = {7'b0000000, 5'd2, 5'd0, 3'b000, 5'd9, 7'b0110011};
    auipc_i  = {20'h12345, 5'd1, 7'b0010111};
    op1      = {12'd7, 5'd2, 3'b000, 5'd10, 7'b0010011};
    op2      = {12'd9, 5'd2, 3'b110, 5'd11, 7'b0010011};
    op3      = {7'b0100000, 5'd3, 5'd2, 3'b000, 5'd12, 7'b0110011};

    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hDEAD_BEEF;
    regs[1] = 32'd10;
    regs[2] = 32'h8000_0F00;
    regs[4] = 32'h24;
    m = '0;
    in_valid = 1'b1; in_instr = 32'hFFF08293; in_pc = 32'h0; out_ready = 1'b0;
    flush = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0; rs1_data = '0; rs2_data = '0;

    #2 check_reset_state("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    step("addi", 1, 32'hFFF08293, 0, 1, 0, 0, 0, 0);
    check("addi.a_const", out_port_a, 32'd10);
    check("addi.b_const", out_port_b, 32'hFFFF_FFFF);
    step("srai", 1, 32'h40415193, 0, 1, 0, 0, 0, 0);
    check("srai.b_const", out_port_b, 32'd4);
    check("srai.op_const", {28'b0, out_alu_op}, 32'd6);
    step("sra", 1, sra_r, 0, 1, 0, 0, 0, 0);
    check("sra.b_const", out_port_b, 32'd4);
    step("slli_bad", 1, slli_bad, 0, 1, 0, 0, 0, 0);
    check("slli_bad.op_const", {28'b0, out_alu_op}, 32'hF);
    step("mul", 1, mul_i, 0, 1, 0, 0, 0, 0);
    check("mul.ill_const", {31'b0, out_illegal}, 32'd1);

    regs[1] = 32'h11;
    step("fwd", 1, add_fwd, 0, 1, 0, 1, 5'd1, 32'h55);
    check("fwd.a_const", out_port_a, 32'h55);
    step("x0", 1, add_x0, 0, 1, 0, 1, 5'd0, 32'h77);
    check("x0.a_const", out_port_a, 32'd0);

    step("auipc", 1, auipc_i, 32'h100, 1, 0, 0, 0, 0);
    check("auipc.a_const", out_port_a, 32'h100);
    check("auipc.b_const", out_port_b, 32'h1234_5000);
    step("drain", 0, 0, 0, 1, 0, 0, 0, 0);
    step("flush_in", 1, auipc_i, 32'h100, 1, 1, 0, 0, 0);
    step("flush_held", 1, op1, 0, 0, 0, 0, 0, 0);
    step("flush_kill", 0, op2, 0, 0, 1, 0, 0, 0);

    step("stall_op1", 1, op1, 0, 0, 0, 0, 0, 0);
    step("stall_hold1", 1, op2, 0, 0, 0, 0, 0, 0);
    step("stall_hold2", 1, op2, 0, 0, 0, 0, 0, 0);
    step("stream_op2", 1, op2, 0, 1, 0, 0, 0, 0);
    step("stream_op3", 1, op3, 0, 1, 0, 0, 0, 0);
    step("stream_end", 0, op3, 0, 1, 0, 0, 0, 0);

    step("rst_hold", 1, op1, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_state("rst_mid");
    m = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0)
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
      case ($urandom_range(0, 4))
        0:       opc = 7'h33;
        1:       opc = 7'h13;
        2:       opc = 7'h37;
        3:       opc = 7'h17;
        default: opc = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      ins        = $urandom;
      ins[31:25] = f7;
      ins[6:0]   = opc;
      wbr        = ($urandom_range(0, 1) == 0) ? ins[19:15] : 5'($urandom);
      step("rand", $urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) == 0, 1'($urandom), wbr, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
